// File: rtl/pht_upd_ctrl_pkg.sv
// Shared fetch-unit definitions for the PHT update path: table geometry,
// counter encodings, update FIFO entry and the saturating counter step.
package pht_upd_ctrl_pkg;

  localparam int INDEXSIZE    = 4096;
  localparam int LOGINDEXSIZE = 12;
  localparam int SATCNTWIDTH  = 2;
  localparam int FIFODEPTH    = 4;

  typedef logic [SATCNTWIDTH-1:0] satcnt_t;

  typedef enum logic [SATCNTWIDTH-1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } satcnt_enc_e;

  localparam satcnt_t SATCNTINIT = satcnt_t'(WT);

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } ctrl_state_e;

  typedef struct packed {
    logic [LOGINDEXSIZE-1:0] idx;
    logic                    dir;
  } upd_entry_t;

  // Shared with the predictor read logic so both sides agree on saturation.
  function automatic satcnt_t sat_update(input satcnt_t cnt, input logic dir);
    satcnt_t w_next;
    if (dir) w_next = (cnt == '1) ? cnt : cnt + satcnt_t'(1);
    else     w_next = (cnt == '0) ? cnt : cnt - satcnt_t'(1);
    return w_next;
  endfunction

endpackage

// File: rtl/pht_upd_fifo.sv
// Small synchronous FIFO holding retired-branch updates {index, direction}
// until the PHT write port is free to apply them.
module pht_upd_fifo
  import pht_upd_ctrl_pkg::*;
#(
  parameter int  DEPTH = FIFODEPTH,
  localparam int PTRW  = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            push,
  input  logic            pop,
  input  logic            flush,
  input  upd_entry_t      wdata,
  output upd_entry_t      rdata,
  output logic            full,
  output logic            empty,
  output logic [PTRW:0]   count
);

  upd_entry_t          r_mem [DEPTH];
  logic [PTRW-1:0]     r_wrPtr;
  logic [PTRW-1:0]     r_rdPtr;
  logic [PTRW:0]       r_count;
  logic                w_doPush;
  logic                w_doPop;

  assign full     = (r_count == (PTRW+1)'(DEPTH));
  assign empty    = (r_count == '0);
  assign w_doPush = push & ~full & ~flush;
  assign w_doPop  = pop & ~empty & ~flush;
  assign rdata    = r_mem[r_rdPtr];
  assign count    = r_count;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTRW'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTRW'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (PTRW+1)'(1);
        2'b01:   r_count <= r_count - (PTRW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_doPush) r_mem[r_wrPtr] <= wdata;
  end

endmodule

// File: rtl/pht_upd_ctrl.sv
// Owner of the PHT write port: clears the table by a one-entry-per-cycle
// sweep, then applies queued branch updates as read-modify-write.
module pht_upd_ctrl
  import pht_upd_ctrl_pkg::*;
#(
  parameter int                       INDEXSIZE    = pht_upd_ctrl_pkg::INDEXSIZE,
  parameter int                       LOGINDEXSIZE = pht_upd_ctrl_pkg::LOGINDEXSIZE,
  parameter int                       SATCNTWIDTH  = pht_upd_ctrl_pkg::SATCNTWIDTH,
  parameter logic [SATCNTWIDTH-1:0]   SATCNTINIT   = pht_upd_ctrl_pkg::SATCNTINIT,
  parameter int                       FIFODEPTH    = pht_upd_ctrl_pkg::FIFODEPTH
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          init_req_i,
  input  logic                          cm_valid_i,
  output logic                          cm_ready_o,
  input  logic [LOGINDEXSIZE-1:0]       cm_index_i,
  input  logic                          cm_brdir_i,
  input  logic                          upd_stall_i,
  output logic [LOGINDEXSIZE-1:0]       pht_upd_rd_index_o,
  input  logic [SATCNTWIDTH-1:0]        pht_upd_rd_cnt_i,
  output logic                          pht_we_o,
  output logic [LOGINDEXSIZE-1:0]       pht_wt_index_o,
  output logic [SATCNTWIDTH-1:0]        pht_wt_cnt_o,
  output logic                          busy_o,
  output logic [$clog2(FIFODEPTH):0]    fifo_cnt_o
);

  ctrl_state_e                r_state;
  ctrl_state_e                w_stateNext;
  logic [LOGINDEXSIZE-1:0]    r_sweepIdx;
  logic [LOGINDEXSIZE-1:0]    w_sweepIdxNext;
  logic                       w_sweepLast;
  logic                       w_fifoPush;
  logic                       w_fifoPop;
  logic                       w_fifoFull;
  logic                       w_fifoEmpty;
  upd_entry_t                 w_fifoWdata;
  upd_entry_t                 w_fifoHead;

  assign w_sweepLast = (r_sweepIdx == LOGINDEXSIZE'(INDEXSIZE - 1));
  assign w_fifoWdata = '{idx: cm_index_i, dir: cm_brdir_i};
  assign w_fifoPush  = cm_valid_i & cm_ready_o;

  pht_upd_fifo #(
    .DEPTH (FIFODEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (w_fifoPush),
    .pop     (w_fifoPop),
    .flush   (init_req_i),
    .wdata   (w_fifoWdata),
    .rdata   (w_fifoHead),
    .full    (w_fifoFull),
    .empty   (w_fifoEmpty),
    .count   (fifo_cnt_o)
  );

  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      r_state    <= SWEEP;
      r_sweepIdx <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_sweepIdx <= w_sweepIdxNext;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_sweepIdxNext = r_sweepIdx;
    if (init_req_i) begin
      w_stateNext    = SWEEP;
      w_sweepIdxNext = '0;
    end else if (r_state == SWEEP) begin
      if (w_sweepLast) begin
        w_stateNext    = RUN;
        w_sweepIdxNext = '0;
      end else begin
        w_sweepIdxNext = r_sweepIdx + LOGINDEXSIZE'(1);
      end
    end
  end

  // Reset gates the outputs directly so the write port stays idle while held.
  // A flush cycle drops the head rather than writing it, since it is discarded.
  always_comb begin
    cm_ready_o         = 1'b0;
    pht_we_o           = 1'b0;
    pht_wt_index_o     = '0;
    pht_wt_cnt_o       = SATCNTINIT;
    pht_upd_rd_index_o = '0;
    busy_o             = 1'b1;
    w_fifoPop          = 1'b0;
    if (!reset_n) begin
      case (r_state)
        SWEEP: begin
          pht_we_o       = 1'b1;
          pht_wt_index_o = r_sweepIdx;
        end
        RUN: begin
          busy_o             = 1'b0;
          cm_ready_o         = ~w_fifoFull & ~init_req_i;
          pht_upd_rd_index_o = w_fifoHead.idx;
          if (!w_fifoEmpty && !upd_stall_i && !init_req_i) begin
            pht_we_o       = 1'b1;
            pht_wt_index_o = w_fifoHead.idx;
            pht_wt_cnt_o   = sat_update(pht_upd_rd_cnt_i, w_fifoHead.dir);
            w_fifoPop      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pht_upd_ctrl.sv
// Self-checking bench for pht_upd_ctrl: directed sweep/flush/reset scenarios
// plus a randomized run scored against a queue-and-table model.
module tb_pht_upd_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        init_req_i;
  logic        cm_valid_i;
  logic        cm_ready_o;
  logic [11:0] cm_index_i;
  logic        cm_brdir_i;
  logic        upd_stall_i;
  logic [11:0] pht_upd_rd_index_o;
  logic [1:0]  pht_upd_rd_cnt_i;
  logic        pht_we_o;
  logic [11:0] pht_wt_index_o;
  logic [1:0]  pht_wt_cnt_o;
  logic        busy_o;
  logic [2:0]  fifo_cnt_o;

  logic [1:0]  pht [4096];
  logic        overrideEn;
  logic [1:0]  overrideVal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int idx;
    bit dir;
  } upd_t;

  pht_upd_ctrl dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .init_req_i         (init_req_i),
    .cm_valid_i         (cm_valid_i),
    .cm_ready_o         (cm_ready_o),
    .cm_index_i         (cm_index_i),
    .cm_brdir_i         (cm_brdir_i),
    .upd_stall_i        (upd_stall_i),
    .pht_upd_rd_index_o (pht_upd_rd_index_o),
    .pht_upd_rd_cnt_i   (pht_upd_rd_cnt_i),
    .pht_we_o           (pht_we_o),
    .pht_wt_index_o     (pht_wt_index_o),
    .pht_wt_cnt_o       (pht_wt_cnt_o),
    .busy_o             (busy_o),
    .fifo_cnt_o         (fifo_cnt_o)
  );

  initial forever #5 clock = ~clock;

  // The bench plays the PHT array itself: a combinational read port and a clocked write port.
  assign pht_upd_rd_cnt_i = overrideEn ? overrideVal : pht[pht_upd_rd_index_o];

  always @(posedge clock) begin
    if (pht_we_o) pht[pht_wt_index_o] <= pht_wt_cnt_o;
  end

  function automatic int satRef(input int c, input bit d);
    int r;
    r = d ? c + 1 : c - 1;
    if (r > 3) r = 3;
    if (r < 0) r = 0;
    return r;
  endfunction

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++; if (pht_we_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %0b expected 0", pht_we_o); end
    checks++; if (cm_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %0b expected 0", cm_ready_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_busy got %0b expected 1", busy_o); end
    checks++; if (fifo_cnt_o !== 3'd0) begin errors++; $display("[TB] FAIL reset_fifo_cnt got %0d expected 0", fifo_cnt_o); end
    checks++; if (pht_wt_index_o !== 12'd0) begin errors++; $display("[TB] FAIL reset_wt_index got %0d expected 0", pht_wt_index_o); end
    checks++; if (pht_wt_cnt_o !== 2'b10) begin errors++; $display("[TB] FAIL reset_wt_cnt got %0d expected 2", pht_wt_cnt_o); end
    checks++; if (pht_upd_rd_index_o !== 12'd0) begin errors++; $display("[TB] FAIL reset_rd_index got %0d expected 0", pht_upd_rd_index_o); end
    nextCycle();
    reset_n = 1'b0;
  endtask

  // Expects to be entered in the cycle whose write is sweep index 0.
  task automatic test_sweep(input string tag);
    for (int i = 0; i < 4096; i++) begin
      @(negedge clock);
      checks++;
      if (pht_we_o !== 1'b1 || pht_wt_index_o !== 12'(i) || pht_wt_cnt_o !== 2'b10 ||
          busy_o !== 1'b1 || cm_ready_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL sweep_%s got we=%0b idx=%0d cnt=%0d busy=%0b ready=%0b expected we=1 idx=%0d cnt=2 busy=1 ready=0",
                 tag, pht_we_o, pht_wt_index_o, pht_wt_cnt_o, busy_o, cm_ready_o, i);
      end
      nextCycle();
    end
    @(negedge clock);
    checks++;
    if (busy_o !== 1'b0 || cm_ready_o !== 1'b1 || pht_we_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sweep_end_%s got busy=%0b ready=%0b we=%0b expected busy=0 ready=1 we=0",
               tag, busy_o, cm_ready_o, pht_we_o);
    end
    nextCycle();
  endtask

  task automatic test_directed();
    int         idxs [4] = '{5, 5, 9, 9};
    bit         dirs [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    bit         ovEn [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0] ovV  [4] = '{2'b00, 2'b00, 2'b00, 2'b01};
    logic [1:0] expC [4] = '{2'b11, 2'b11, 2'b00, 2'b00};
    for (int k = 0; k < 4; k++) begin
      overrideEn  = ovEn[k];
      overrideVal = ovV[k];
      cm_valid_i  = 1'b1;
      cm_index_i  = 12'(idxs[k]);
      cm_brdir_i  = dirs[k];
      @(negedge clock);
      checks++;
      if (cm_ready_o !== 1'b1 || pht_we_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL directed_offer%0d got ready=%0b we=%0b expected ready=1 we=0", k, cm_ready_o, pht_we_o);
      end
      nextCycle();
      cm_valid_i = 1'b0;
      @(negedge clock);
      checks++;
      if (pht_we_o !== 1'b1 || pht_wt_index_o !== 12'(idxs[k]) || pht_wt_cnt_o !== expC[k] ||
          pht_upd_rd_index_o !== 12'(idxs[k])) begin
        errors++;
        $display("[TB] FAIL directed_write%0d got we=%0b idx=%0d cnt=%0d rd=%0d expected we=1 idx=%0d cnt=%0d",
                 k, pht_we_o, pht_wt_index_o, pht_wt_cnt_o, pht_upd_rd_index_o, idxs[k], expC[k]);
      end
      nextCycle();
    end
    overrideEn = 1'b0;
  endtask

  task automatic test_stall();
    upd_stall_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cm_valid_i = 1'b1;
      cm_index_i = 12'(20 + k);
      cm_brdir_i = (k % 2 == 0);
      @(negedge clock);
      checks++;
      if (cm_ready_o !== (k < 4) || int'(fifo_cnt_o) != k || pht_we_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stall_push%0d got ready=%0b cnt=%0d we=%0b expected ready=%0b cnt=%0d we=0",
                 k, cm_ready_o, fifo_cnt_o, pht_we_o, (k < 4), k);
      end
      nextCycle();
    end
    cm_valid_i = 1'b0;
    @(negedge clock);
    checks++;
    if (cm_ready_o !== 1'b0 || fifo_cnt_o !== 3'd4 || pht_we_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_full got ready=%0b cnt=%0d we=%0b expected ready=0 cnt=4 we=0", cm_ready_o, fifo_cnt_o, pht_we_o);
    end
    nextCycle();
    upd_stall_i = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      checks++;
      if (pht_we_o !== 1'b1 || pht_wt_index_o !== 12'(20 + j) || pht_wt_cnt_o !== ((j % 2 == 0) ? 2'b11 : 2'b01) ||
          int'(fifo_cnt_o) != 4 - j) begin
        errors++;
        $display("[TB] FAIL stall_drain%0d got we=%0b idx=%0d cnt=%0d occ=%0d expected we=1 idx=%0d cnt=%0d occ=%0d",
                 j, pht_we_o, pht_wt_index_o, pht_wt_cnt_o, fifo_cnt_o, 20 + j, (j % 2 == 0) ? 3 : 1, 4 - j);
      end
      nextCycle();
    end
    @(negedge clock);
    checks++;
    if (pht_we_o !== 1'b0 || fifo_cnt_o !== 3'd0) begin
      errors++;
      $display("[TB] FAIL stall_empty got we=%0b cnt=%0d expected we=0 cnt=0", pht_we_o, fifo_cnt_o);
    end
    nextCycle();
  endtask

  // Leaves the bench in the first sweep cycle so test_sweep can follow directly.
  task automatic test_init_flush();
    upd_stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cm_valid_i = 1'b1;
      cm_index_i = 12'(30 + k);
      cm_brdir_i = 1'b1;
      @(negedge clock);
      checks++;
      if (cm_ready_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL flush_push%0d got ready=%0b expected 1", k, cm_ready_o);
      end
      nextCycle();
    end
    cm_valid_i = 1'b0;
    init_req_i = 1'b1;
    @(negedge clock);
    checks++;
    if (cm_ready_o !== 1'b0 || fifo_cnt_o !== 3'd3) begin
      errors++;
      $display("[TB] FAIL flush_req got ready=%0b cnt=%0d expected ready=0 cnt=3", cm_ready_o, fifo_cnt_o);
    end
    nextCycle();
    init_req_i  = 1'b0;
    upd_stall_i = 1'b0;
    #1;
    checks++;
    if (fifo_cnt_o !== 3'd0 || busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_after got cnt=%0d busy=%0b expected cnt=0 busy=1", fifo_cnt_o, busy_o);
    end
  endtask

  task automatic test_post_flush_idle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checks++;
      if (pht_we_o !== 1'b0 || fifo_cnt_o !== 3'd0) begin
        errors++;
        $display("[TB] FAIL flush_idle%0d got we=%0b cnt=%0d expected we=0 cnt=0", k, pht_we_o, fifo_cnt_o);
      end
      nextCycle();
    end
  endtask

  // Table entries 0..15 hold weakly-taken after the preceding sweep.
  task automatic test_random();
    upd_t q[$];
    int   refTab [16];
    bit   expReady;
    upd_t h;
    int   expCnt;
    for (int i = 0; i < 16; i++) refTab[i] = 2;
    for (int cyc = 0; cyc < 410; cyc++) begin
      if (cyc < 400) begin
        cm_valid_i  = ($urandom_range(0, 9) < 6);
        upd_stall_i = ($urandom_range(0, 3) == 0);
      end else begin
        cm_valid_i  = 1'b0;
        upd_stall_i = 1'b0;
      end
      cm_index_i = 12'($urandom_range(0, 15));
      cm_brdir_i = 1'($urandom_range(0, 1));
      @(negedge clock);
      expReady = (q.size() < 4);
      checks++;
      if (cm_ready_o !== expReady || int'(fifo_cnt_o) != q.size()) begin
        errors++;
        $display("[TB] FAIL rand_occ cyc=%0d got ready=%0b cnt=%0d expected ready=%0b cnt=%0d",
                 cyc, cm_ready_o, fifo_cnt_o, expReady, q.size());
      end
      if (q.size() > 0 && !upd_stall_i) begin
        h = q.pop_front();
        expCnt = satRef(refTab[h.idx], h.dir);
        refTab[h.idx] = expCnt;
        checks++;
        if (pht_we_o !== 1'b1 || pht_wt_index_o !== 12'(h.idx) || pht_wt_cnt_o !== 2'(expCnt)) begin
          errors++;
          $display("[TB] FAIL rand_write cyc=%0d got we=%0b idx=%0d cnt=%0d expected we=1 idx=%0d cnt=%0d",
                   cyc, pht_we_o, pht_wt_index_o, pht_wt_cnt_o, h.idx, expCnt);
        end
      end else begin
        checks++;
        if (pht_we_o !== 1'b0) begin
          errors++;
          $display("[TB] FAIL rand_nowrite cyc=%0d got we=%0b expected 0", cyc, pht_we_o);
        end
      end
      if (cm_valid_i && expReady) q.push_back('{idx: int'(cm_index_i), dir: cm_brdir_i});
      nextCycle();
    end
  endtask

  task automatic test_reset_mid_sweep();
    init_req_i = 1'b1;
    nextCycle();
    init_req_i = 1'b0;
    repeat (100) nextCycle();
    checks++;
    if (pht_wt_index_o !== 12'd100 || pht_we_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midreset_pre got idx=%0d we=%0b expected idx=100 we=1", pht_wt_index_o, pht_we_o);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (pht_we_o !== 1'b0 || cm_ready_o !== 1'b0 || busy_o !== 1'b1 || fifo_cnt_o !== 3'd0 ||
        pht_wt_index_o !== 12'd0 || pht_wt_cnt_o !== 2'b10 || pht_upd_rd_index_o !== 12'd0) begin
      errors++;
      $display("[TB] FAIL midreset_hold got we=%0b ready=%0b busy=%0b cnt=%0d widx=%0d wcnt=%0d ridx=%0d expected 0 0 1 0 0 2 0",
               pht_we_o, cm_ready_o, busy_o, fifo_cnt_o, pht_wt_index_o, pht_wt_cnt_o, pht_upd_rd_index_o);
    end
    nextCycle();
    reset_n = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b1;
    init_req_i  = 1'b0;
    cm_valid_i  = 1'b0;
    cm_index_i  = '0;
    cm_brdir_i  = 1'b0;
    upd_stall_i = 1'b0;
    overrideEn  = 1'b0;
    overrideVal = '0;
    $display("[TB] start");
    test_reset();
    test_sweep("post_reset");
    test_directed();
    test_stall();
    test_init_flush();
    test_sweep("after_init");
    test_post_flush_idle();
    test_random();
    test_reset_mid_sweep();
    test_sweep("after_midreset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
